rocket_launch_scheduler: RTL and testbench
==========================================

// Module: rocket_launch_scheduler
// PURPOSE
// - Owns a pool of NUM_SLOTS rocket-controller instances and shares them between NUM_REQ fire requesters.
//   - Requester 0 is the player; requesters 1.. are alien shooters.
// - Per slot, drives initialX/initialY/initialSpeed and isActive. Frees the slot on reachedBorder or hit.
// - Enforces a per-requester cooldown measured in frames.
// - Sits between game logic (fire buttons, alien AI, collision) and the rocket controllers.
// PARAMETERS
// - NUM_SLOTS        4   rocket controller instances managed (1..8)
// - NUM_REQ          2   fire requesters (1..4)
// - COOLDOWN_FRAMES  8   frames a requester is blocked after a granted launch (0 = none)
// - MAX_PER_REQ      2   live rockets allowed per requester (used only with ROCKET_PER_REQ_LIMIT_EN)
// PORTS
// - clk           in   1              system clock
// - resetN        in   1              asynchronous, active-low reset
// - startOfFrame  in   1              one-clk pulse per frame
// - fireReq       in   NUM_REQ        level request; held until fireAck
// - fireX         in   NUM_REQ*11     signed launch X per requester, requester r at [r*11+:11]
// - fireY         in   NUM_REQ*11     signed launch Y per requester
// - fireSpeed     in   NUM_REQ*11     signed speed per requester, in (pixels/64)/frame
// - reachedBorder in   NUM_SLOTS      from each rocket controller
// - hit           in   NUM_SLOTS      collision-kill per slot, from collision logic
// - fireAck       out  NUM_REQ        one-clk pulse: request granted
// - isActive      out  NUM_SLOTS      rocket enable to each controller
// - initialX      out  NUM_SLOTS*11   latched launch X per slot
// - initialY      out  NUM_SLOTS*11   latched launch Y per slot
// - initialSpeed  out  NUM_SLOTS*11   latched speed per slot
// - slotOwner     out  NUM_SLOTS*2    requester index owning each slot (valid while isActive)
// - poolFull      out  1              no slot in IDLE
// BEHAVIOUR
// - Reset: all outputs 0; all slots IDLE; cooldowns 0; round-robin pointer 0. Reset mid-flight kills every rocket immediately.
// - Slot FSM:
//   - IDLE -> LOAD on grant.
//   - LOAD -> ACTIVE after exactly 1 clk.
//   - ACTIVE -> IDLE when (reachedBorder | hit) is sampled high.
//   - isActive=1 only in ACTIVE. initialX/Y/Speed are written in the grant cycle and held until the next grant to that slot.
//   - Result: launch values are stable at least 1 clk before the isActive rising edge.
//   - IDLE lasts at least 1 clk, so every relaunch produces a fresh rising edge.
// - Grant cycle:
//   - Eligible requester: fireReq=1, cooldown=0, and a free (IDLE) slot exists.
//   - Round-robin starting at the pointer picks one eligible requester; the lowest-index IDLE slot is allocated.
//   - The grant registers fireAck (high the next clk) and moves the slot to LOAD.
//   - The pointer advances to winner+1 mod NUM_REQ.
//   - At most one grant per clk.
// - Latency: fireReq sampled high -> fireAck and LOAD in the next clk -> isActive high 1 clk later.
// - Request hold: a requester still asserting fireReq in the fireAck cycle is not granted again in that cycle; cooldown blocks it.
// - Cooldown: loaded with COOLDOWN_FRAMES on grant. Decrements on startOfFrame while nonzero, saturating at 0.
//   - Grant and startOfFrame in the same clk: the load wins.
// - Release priority: reachedBorder and hit in the same clk produce a single release.
//   - A release while the slot is not ACTIVE is ignored.
// - Simultaneous release + request: a slot freed in clk N is grantable from clk N+1, not in clk N.
// - poolFull = no IDLE slot, registered alongside the slot states.
// - Widths: fire inputs are copied unmodified; no arithmetic on positions.
// CONFIGURATION
// - ROCKET_PER_REQ_LIMIT_EN defined:
//   - Per-requester live counter: +1 on grant, -1 on release of an owned slot (same clk: net 0).
//   - A requester with count == MAX_PER_REQ is ineligible.
// - ROCKET_PER_REQ_LIMIT_EN undefined: no counters; only cooldown and slot availability gate grants.
// TESTING
// - Reset release, no requests -> isActive=0, fireAck=0, poolFull=0 indefinitely.
// - Req0 with X=100, Y=400, speed=-128 -> fireAck[0] next clk; slot0 isActive rises 1 clk later.
//   - initialX/Y/Speed of slot0 read 100/400/-128 in the cycle before the rise.
// - Req0 and req1 held together, COOLDOWN_FRAMES=0 -> grants alternate 0,1,0,1.
//   - Slots fill 0..3, poolFull=1; further fireAck stays 0.
// - Slot2 ACTIVE with reachedBorder and hit pulsed together -> isActive[2]=0 next clk.
//   - A pending request is granted slot2 the clk after that.
// - COOLDOWN_FRAMES=8, req0 held -> second fireAck[0] only after the 8th startOfFrame after the first grant.
// - resetN low while 3 slots ACTIVE -> all isActive=0 asynchronously; requests after release start from slot0.
//   - With ROCKET_PER_REQ_LIMIT_EN, the third req0 with two live rockets gets no ack.

Source files
------------

// File: rtl/rocket_launch_scheduler_if.sv
// Game-logic <-> rocket launch scheduler bundle; game logic is the master, the scheduler the slave.
interface rocket_launch_scheduler_if #(
    parameter int NUM_SLOTS = 4,
    parameter int NUM_REQ   = 2
);
    logic                      startOfFrame;
    logic [NUM_REQ-1:0]        fireReq;
    logic [NUM_REQ*11-1:0]     fireX;
    logic [NUM_REQ*11-1:0]     fireY;
    logic [NUM_REQ*11-1:0]     fireSpeed;
    logic [NUM_SLOTS-1:0]      reachedBorder;
    logic [NUM_SLOTS-1:0]      hit;
    logic [NUM_REQ-1:0]        fireAck;
    logic [NUM_SLOTS-1:0]      isActive;
    logic [NUM_SLOTS*11-1:0]   initialX;
    logic [NUM_SLOTS*11-1:0]   initialY;
    logic [NUM_SLOTS*11-1:0]   initialSpeed;
    logic [NUM_SLOTS*2-1:0]    slotOwner;
    logic                      poolFull;

    modport master (
        output startOfFrame, fireReq, fireX, fireY, fireSpeed, reachedBorder, hit,
        input  fireAck, isActive, initialX, initialY, initialSpeed, slotOwner, poolFull
    );

    modport slave (
        input  startOfFrame, fireReq, fireX, fireY, fireSpeed, reachedBorder, hit,
        output fireAck, isActive, initialX, initialY, initialSpeed, slotOwner, poolFull
    );
endinterface

// File: rtl/rocket_launch_scheduler.sv
// Shares NUM_SLOTS rocket controllers among NUM_REQ fire requesters (round-robin, frame cooldown).
// Define ROCKET_PER_REQ_LIMIT_EN to also cap live rockets per requester at MAX_PER_REQ.

module rocket_launch_slot (
    input  logic        clk,
    input  logic        resetN,
    input  logic        i_grant,
    input  logic        i_release,
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    input  logic [10:0] i_speed,
    input  logic [1:0]  i_owner,
    output logic        o_idle,
    output logic        o_active,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic [10:0] o_speed,
    output logic [1:0]  o_owner
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;
    state_t r_state, w_next;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_grant) w_next = S_LOAD;
            S_LOAD:   w_next = S_ACTIVE;
            S_ACTIVE: if (i_release) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // LOAD gives the controller one clk of stable launch values before isActive rises
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            o_x     <= '0;
            o_y     <= '0;
            o_speed <= '0;
            o_owner <= '0;
        end else if (i_grant) begin
            o_x     <= i_x;
            o_y     <= i_y;
            o_speed <= i_speed;
            o_owner <= i_owner;
        end
    end

    assign o_idle   = (r_state == S_IDLE);
    assign o_active = (r_state == S_ACTIVE);
endmodule

module rocket_launch_scheduler #(
    parameter int NUM_SLOTS       = 4,
    parameter int NUM_REQ         = 2,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MAX_PER_REQ     = 2
) (
    input  logic                      clk,
    input  logic                      resetN,
    rocket_launch_scheduler_if.slave  bus
);
    localparam int RW = (NUM_REQ > 1)         ? $clog2(NUM_REQ)             : 1;
    localparam int SW = (NUM_SLOTS > 1)       ? $clog2(NUM_SLOTS)           : 1;
    localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic [NUM_SLOTS-1:0]         w_idle, w_active, w_release, w_slot_gnt;
    logic [NUM_SLOTS-1:0][1:0]    w_owner;
    logic [NUM_REQ-1:0]           r_fireAck, w_ack_nxt, w_elig, w_under;
    logic [NUM_REQ-1:0][CW-1:0]   r_cool;
    logic [RW-1:0]                r_ptr, w_win;
    logic [SW-1:0]                w_slot;
    logic                         w_gnt;
    logic [10:0]                  w_x, w_y, w_spd;
    logic [1:0]                   w_own_in;

    // only an ACTIVE slot can be released; border+hit together is one release
    assign w_release = w_active & (bus.reachedBorder | bus.hit);

`ifdef ROCKET_PER_REQ_LIMIT_EN
    localparam int LW = $clog2(NUM_SLOTS + 1);
    logic [NUM_REQ-1:0][LW-1:0] r_live, w_live_nxt;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            w_live_nxt[r] = r_live[r];
            if (w_ack_nxt[r]) w_live_nxt[r] = w_live_nxt[r] + LW'(1);
            for (int s = 0; s < NUM_SLOTS; s++)
                if (w_release[s] && (int'(w_owner[s]) == r)) w_live_nxt[r] = w_live_nxt[r] - LW'(1);
            w_under[r] = (r_live[r] < LW'(MAX_PER_REQ));
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_live <= '0;
        else         r_live <= w_live_nxt;
    end
`else
    assign w_under = '1;
`endif

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++)
            w_elig[r] = bus.fireReq[r] && (r_cool[r] == '0) && !r_fireAck[r] && w_under[r];
        w_gnt = 1'b0;
        w_win = '0;
        if (|w_idle) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_gnt && w_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
                    w_gnt = 1'b1;
                    w_win = RW'((int'(r_ptr) + k) % NUM_REQ);
                end
            end
        end
        w_slot = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--)
            if (w_idle[s]) w_slot = SW'(s);
        for (int r = 0; r < NUM_REQ; r++)
            w_ack_nxt[r] = w_gnt && (int'(w_win) == r);
    end

    assign w_x      = bus.fireX[int'(w_win)*11 +: 11];
    assign w_y      = bus.fireY[int'(w_win)*11 +: 11];
    assign w_spd    = bus.fireSpeed[int'(w_win)*11 +: 11];
    assign w_own_in = 2'(w_win);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_fireAck <= '0;
            r_ptr     <= '0;
            r_cool    <= '0;
        end else begin
            r_fireAck <= w_ack_nxt;
            if (w_gnt) r_ptr <= RW'((int'(w_win) + 1) % NUM_REQ);
            // a grant reload beats a same-clk startOfFrame decrement
            for (int r = 0; r < NUM_REQ; r++) begin
                if (w_ack_nxt[r])
                    r_cool[r] <= CW'(COOLDOWN_FRAMES);
                else if (bus.startOfFrame && (r_cool[r] != '0))
                    r_cool[r] <= r_cool[r] - CW'(1);
            end
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        assign w_slot_gnt[s] = w_gnt && (int'(w_slot) == s);

        rocket_launch_slot u_slot (
            .clk       (clk),
            .resetN    (resetN),
            .i_grant   (w_slot_gnt[s]),
            .i_release (w_release[s]),
            .i_x       (w_x),
            .i_y       (w_y),
            .i_speed   (w_spd),
            .i_owner   (w_own_in),
            .o_idle    (w_idle[s]),
            .o_active  (w_active[s]),
            .o_x       (bus.initialX[s*11 +: 11]),
            .o_y       (bus.initialY[s*11 +: 11]),
            .o_speed   (bus.initialSpeed[s*11 +: 11]),
            .o_owner   (w_owner[s])
        );
    end

    assign bus.fireAck   = r_fireAck;
    assign bus.isActive  = w_active;
    assign bus.slotOwner = w_owner;
    assign bus.poolFull  = ~|w_idle;
endmodule

// File: tb/tb_rocket_launch_scheduler.sv
// Bench for rocket_launch_scheduler: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a slot/timestamp-level reference model.
module tb_rocket_launch_scheduler;
    localparam int NS  = 4;
    localparam int NR  = 2;
    localparam int CD  = 8;
    localparam int MPR = 2;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    rocket_launch_scheduler_if #(.NUM_SLOTS(NS), .NUM_REQ(NR)) bus ();

    rocket_launch_scheduler #(
        .NUM_SLOTS(NS), .NUM_REQ(NR), .COOLDOWN_FRAMES(CD), .MAX_PER_REQ(MPR)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // reference model: a slot is "alive" from its grant until released; it is visible
    // as active from two steps after the grant step
    int          cyc;
    bit          m_alive [NS];
    int          m_gcyc  [NS];
    logic [10:0] m_x [NS], m_y [NS], m_s [NS];
    int          m_own [NS];
    int          m_cool [NR];
    int          m_live [NR];
    int          m_ptr;
    logic [NR-1:0] m_ack;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_alive[s] = 1'b0; m_gcyc[s] = 0; m_own[s] = 0;
            m_x[s] = '0; m_y[s] = '0; m_s[s] = '0;
        end
        for (int r = 0; r < NR; r++) begin
            m_cool[r] = 0; m_live[r] = 0;
        end
        m_ptr = 0;
        m_ack = '0;
    endtask

    task automatic model_step();
        int  win, slot, idx;
        bit  gv, any_free, lim_ok;
        if (!resetN) begin
            model_reset();
            return;
        end
        any_free = 1'b0;
        slot     = -1;
        for (int s = 0; s < NS; s++)
            if (!m_alive[s]) begin
                any_free = 1'b1;
                if (slot < 0) slot = s;
            end
        gv  = 1'b0;
        win = 0;
        for (int k = 0; k < NR; k++) begin
            idx    = (m_ptr + k) % NR;
            lim_ok = 1'b1;
`ifdef ROCKET_PER_REQ_LIMIT_EN
            lim_ok = (m_live[idx] < MPR);
`endif
            if (!gv && any_free && bus.fireReq[idx] && m_cool[idx] == 0 && !m_ack[idx] && lim_ok) begin
                gv  = 1'b1;
                win = idx;
            end
        end
        for (int s = 0; s < NS; s++)
            if (m_alive[s] && cyc >= m_gcyc[s] + 2 && (bus.reachedBorder[s] || bus.hit[s])) begin
                m_alive[s] = 1'b0;
                m_live[m_own[s]]--;
            end
        for (int r = 0; r < NR; r++)
            if (gv && r == win)                       m_cool[r] = CD;
            else if (bus.startOfFrame && m_cool[r] > 0) m_cool[r]--;
        m_ack = '0;
        if (gv) begin
            m_alive[slot] = 1'b1;
            m_gcyc[slot]  = cyc;
            m_x[slot]     = bus.fireX[win*11 +: 11];
            m_y[slot]     = bus.fireY[win*11 +: 11];
            m_s[slot]     = bus.fireSpeed[win*11 +: 11];
            m_own[slot]   = win;
            m_ack[win]    = 1'b1;
            m_ptr         = (win + 1) % NR;
            m_live[win]++;
        end
        cyc++;
    endtask

    task automatic compare_all();
        logic [NS-1:0]    e_act;
        logic [NS*11-1:0] ex, ey, es;
        logic [NS*2-1:0]  eo;
        bit               full;
        full = 1'b1;
        for (int s = 0; s < NS; s++) begin
            e_act[s]        = m_alive[s] && (cyc >= m_gcyc[s] + 2);
            ex[s*11 +: 11]  = m_x[s];
            ey[s*11 +: 11]  = m_y[s];
            es[s*11 +: 11]  = m_s[s];
            eo[s*2 +: 2]    = 2'(m_own[s]);
            if (!m_alive[s]) full = 1'b0;
        end
        chk("model_fireAck",      bus.fireAck,      m_ack);
        chk("model_isActive",     bus.isActive,     e_act);
        chk("model_poolFull",     bus.poolFull,     full);
        chk("model_initialX",     bus.initialX,     ex);
        chk("model_initialY",     bus.initialY,     ey);
        chk("model_initialSpeed", bus.initialSpeed, es);
        chk("model_slotOwner",    bus.slotOwner,    eo);
    endtask

    // one clock: model follows the DUT's sampling edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (resetN) compare_all();
    endtask

    task automatic sof_frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.startOfFrame = 1'b1;
            tick();
            bus.startOfFrame = 1'b0;
            chk("sof_noack", bus.fireAck, 0);
            tick();
            chk("sof_noack", bus.fireAck, 0);
        end
    endtask

    initial begin
        resetN            = 1'b0;
        bus.startOfFrame  = 1'b0;
        bus.fireReq       = '0;
        bus.fireX         = '0;
        bus.fireY         = '0;
        bus.fireSpeed     = '0;
        bus.reachedBorder = '0;
        bus.hit           = '0;
        cyc = 0;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        chk("rst_isActive", bus.isActive, 0);
        chk("rst_fireAck",  bus.fireAck,  0);
        chk("rst_poolFull", bus.poolFull, 0);
        resetN = 1'b1;

        repeat (6) tick();
        chk("idle_isActive", bus.isActive, 0);
        chk("idle_fireAck",  bus.fireAck,  0);
        chk("idle_poolFull", bus.poolFull, 0);

        // first launch: X=100, Y=400, speed=-128 (11'h780)
        bus.fireReq             = 2'b01;
        bus.fireX[10:0]         = 11'd100;
        bus.fireY[10:0]         = 11'd400;
        bus.fireSpeed[10:0]     = 11'h780;
        tick();
        chk("launch_ack",       bus.fireAck,              2'b01);
        chk("launch_not_yet",   bus.isActive,             0);
        chk("launch_x",         bus.initialX[10:0],       100);
        chk("launch_y",         bus.initialY[10:0],       400);
        chk("launch_speed",     bus.initialSpeed[10:0],   11'h780);
        tick();
        chk("launch_active",    bus.isActive,             4'b0001);
        chk("launch_no_reack",  bus.fireAck,              0);

        // req0 held through cooldown: re-grant only after the 8th frame pulse
        for (int i = 1; i <= CD; i++) begin
            bus.startOfFrame = 1'b1;
            tick();
            bus.startOfFrame = 1'b0;
            chk("cool_blocked", bus.fireAck, 0);
            tick();
            if (i < CD) chk("cool_blocked", bus.fireAck, 0);
            else        chk("cool_regrant", bus.fireAck, 2'b01);
        end
        bus.fireReq = 2'b00;

        bus.fireReq         = 2'b10;
        bus.fireX[21:11]    = 11'd7;
        bus.fireY[21:11]    = 11'd9;
        bus.fireSpeed[21:11]= 11'd64;
        tick();
        chk("req1_ack",       bus.fireAck,  2'b10);
        chk("req1_active01",  bus.isActive, 4'b0011);
        bus.fireReq = 2'b00;
        tick();
        chk("req1_active012", bus.isActive, 4'b0111);
        sof_frames(CD);

        // fill slot3, then hold req1 against a full pool
        bus.fireReq = 2'b10;
        tick();
        chk("fill_ack",      bus.fireAck,  2'b10);
        chk("fill_poolFull", bus.poolFull, 1);
        sof_frames(CD);
        tick();
        chk("full_noack",    bus.fireAck,  0);
        bus.reachedBorder[2] = 1'b1;
        bus.hit[2]           = 1'b1;
        tick();
        bus.reachedBorder = '0;
        bus.hit           = '0;
        chk("release_slot2",     bus.isActive, 4'b1011);
        chk("release_same_noack", bus.fireAck, 0);
        tick();
        chk("refill_ack",   bus.fireAck,        2'b10);
        chk("refill_owner", bus.slotOwner[5:4], 1);
        bus.fireReq = 2'b00;
        tick();
        tick();
        chk("all_active", bus.isActive, 4'hF);

        // asynchronous reset mid-flight
        #2 resetN = 1'b0;
        #1;
        chk("async_isActive", bus.isActive, 0);
        chk("async_poolFull", bus.poolFull, 0);
        chk("async_fireAck",  bus.fireAck,  0);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        bus.fireReq = 2'b01;
        tick();
        chk("postrst_ack", bus.fireAck, 2'b01);
        bus.fireReq = 2'b00;
        tick();
        chk("postrst_slot0", bus.isActive, 4'b0001);

`ifdef ROCKET_PER_REQ_LIMIT_EN
        sof_frames(CD);
        bus.fireReq = 2'b01;
        tick();
        chk("limit_second_ack", bus.fireAck, 2'b01);
        sof_frames(CD);
        repeat (4) begin
            tick();
            chk("limit_third_noack", bus.fireAck, 0);
        end
        bus.hit[0] = 1'b1;
        tick();
        bus.hit[0] = 1'b0;
        chk("limit_release_noack", bus.fireAck, 0);
        tick();
        chk("limit_regrant", bus.fireAck, 2'b01);
        bus.fireReq = 2'b00;
`endif

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            resetN            = 1'b1;
            bus.fireReq       = NR'($urandom_range(0, (1 << NR) - 1));
            bus.startOfFrame  = ($urandom_range(0, 2) == 0);
            bus.fireX         = {$urandom, $urandom};
            bus.fireY         = {$urandom, $urandom};
            bus.fireSpeed     = {$urandom, $urandom};
            for (int s = 0; s < NS; s++) begin
                bus.reachedBorder[s] = ($urandom_range(0, 11) == 0);
                bus.hit[s]           = ($urandom_range(0, 11) == 0);
            end
            if ($urandom_range(0, 599) == 0) begin
                resetN = 1'b0;
                model_reset();
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
